// File: rtl/rf_dump_pkg.sv
// Shared constants for the register-file UART dump: state codes, frame geometry, default header
// and the snapshot byte selector (big-endian, RF1 first).
package rf_dump_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam int FRAME_BYTES = 42;
  localparam int DATA_BYTES  = 40;
  localparam int NUM_REGS    = 10;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // Frame byte idx (1..DATA_BYTES) out of the flattened snapshot; header/checksum slots read as 0.
  function automatic logic [7:0] snap_byte(input logic [NUM_REGS*32-1:0] snap,
                                           input logic [5:0]             idx);
    logic [8:0]             sh;
    logic [NUM_REGS*32-1:0] shifted;
    snap_byte = 8'h00;
    if (idx >= 6'd1 && int'(idx) <= DATA_BYTES) begin
      sh        = 9'((DATA_BYTES - int'(idx)) * 8);
      shifted   = snap >> sh;
      snap_byte = shifted[7:0];
    end
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: a load while o_ready starts the start bit on the next cycle; o_ready is also
// high in the last stop-bit cycle so a load there chains bytes with no idle gap.
module uart_tx_byte
  import rf_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_byte_done,
  output logic       o_tx
);

  localparam int             BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;

  logic w_bit_end;
  logic w_stop_end;

  assign w_bit_end   = (r_baud == BAUD_MAX);
  assign w_stop_end  = (r_state == ST_STOP) && w_bit_end;
  assign o_ready     = (r_state == ST_IDLE) || w_stop_end;
  assign o_byte_done = w_stop_end;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state != ST_IDLE) begin
        r_baud <= w_bit_end ? '0 : r_baud + BW'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_state   <= ST_START;
            r_shift   <= i_data;
            r_baud    <= '0;
            r_bit_idx <= '0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (i_load) begin
              r_state <= ST_START;
              r_shift <= i_data;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_tx = 1'b1;
    case (r_state)
      ST_START: o_tx = 1'b0;
      ST_DATA:  o_tx = r_shift[r_bit_idx];
      default:  o_tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/rf_uart_dump.sv
// Snapshots RF1..RF10 on start and streams a 42-byte 8N1 frame (header, 40 data bytes, XOR checksum).
// uart_tx/busy move one cycle after the accepting edge; start is ignored unless idle, never queued.
module rf_uart_dump
  import rf_dump_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER_BYTE  = DEFAULT_HEADER
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] RF1,
  input  logic [31:0] RF2,
  input  logic [31:0] RF3,
  input  logic [31:0] RF4,
  input  logic [31:0] RF5,
  input  logic [31:0] RF6,
  input  logic [31:0] RF7,
  input  logic [31:0] RF8,
  input  logic [31:0] RF9,
  input  logic [31:0] RF10,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] LAST_IDX = 6'(FRAME_BYTES - 1);

  // ST_DATA here means "frame in flight"; bit-level phases live in the serialiser.
  state_t                 r_state;
  logic [NUM_REGS*32-1:0] r_snap;
  logic [5:0]             r_byte_idx;
  logic [7:0]             r_csum;

  logic       w_tx_ready;
  logic       w_byte_done;
  logic       w_accept;
  logic       w_last;
  logic       w_load;
  logic [7:0] w_cur_byte;
  logic [7:0] w_csum_fold;
  logic [5:0] w_next_idx;
  logic [7:0] w_next_byte;

  assign w_accept    = start && (r_state == ST_IDLE) && w_tx_ready;
  assign w_last      = (r_byte_idx == LAST_IDX);
  assign w_cur_byte  = snap_byte(r_snap, r_byte_idx);
  assign w_csum_fold = r_csum ^ w_cur_byte;
  assign w_next_idx  = w_accept ? 6'd0 : r_byte_idx + 6'd1;
  assign w_load      = w_accept || ((r_state == ST_DATA) && w_byte_done && !w_last);

  // Checksum byte already includes the data byte whose stop bit is ending this cycle.
  always_comb begin
    w_next_byte = snap_byte(r_snap, w_next_idx);
    if (w_next_idx == 6'd0)          w_next_byte = HEADER_BYTE;
    else if (w_next_idx == LAST_IDX) w_next_byte = w_csum_fold;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_snap     <= '0;
      r_byte_idx <= '0;
      r_csum     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_snap     <= {RF1, RF2, RF3, RF4, RF5, RF6, RF7, RF8, RF9, RF10};
            r_byte_idx <= '0;
            r_csum     <= '0;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_byte_done) begin
            r_csum <= w_csum_fold;
            if (w_last) r_state    <= ST_DONE;
            else        r_byte_idx <= r_byte_idx + 6'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_load      (w_load),
    .i_data      (w_next_byte),
    .o_ready     (w_tx_ready),
    .o_byte_done (w_byte_done),
    .o_tx        (uart_tx)
  );

  assign busy = (r_state == ST_DATA);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_rf_uart_dump.sv
// Scoreboard bench: stimulus queues expected frame bytes, a UART monitor decodes the line and pops.
module tb_rf_uart_dump;

  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] rf_v [10];
  logic        uart_tx;
  logic        busy;
  logic        done;

  int          cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  logic [7:0]  exp_q [$];
  logic        mon_flush = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  rf_uart_dump #(.CLKS_PER_BIT(CPB), .HEADER_BYTE(8'hA5)) dut (
    .clock(clock), .reset(reset), .start(start),
    .RF1(rf_v[0]), .RF2(rf_v[1]), .RF3(rf_v[2]), .RF4(rf_v[3]), .RF5(rf_v[4]),
    .RF6(rf_v[5]), .RF7(rf_v[6]), .RF8(rf_v[7]), .RF9(rf_v[8]), .RF10(rf_v[9]),
    .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected frame from the current RF values; checksum is hand-computed by the caller.
  task automatic push_frame(input logic [7:0] csum);
    exp_q.push_back(8'hA5);
    for (int r = 0; r < 10; r++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(rf_v[r][31-8*b -: 8]);
    exp_q.push_back(csum);
  endtask

  task automatic set_rf(input logic [31:0] v);
    for (int r = 0; r < 10; r++) rf_v[r] = v;
  endtask

  task automatic pulse_start(input bit chk);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    if (chk) begin
      check("accept_busy", busy, 1);
      check("accept_tx", uart_tx, 0);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("done_seen", done, 1);
  endtask

  initial begin : uart_mon
    logic       prev;
    logic       s [40];
    logic       ok;
    logic       aborted;
    logic [7:0] got;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (mon_flush) begin
        prev = 1'b1;
      end else if (prev === 1'b1 && uart_tx === 1'b0) begin
        s[0] = uart_tx;
        aborted = 1'b0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clock);
          if (mon_flush) begin
            aborted = 1'b1;
            break;
          end
          s[i] = uart_tx;
        end
        if (aborted) begin
          prev = 1'b1;
        end else begin
          ok = 1'b1;
          got = 8'h00;
          for (int b = 0; b < 10; b++)
            for (int k = 1; k < CPB; k++)
              if (s[b*CPB+k] !== s[b*CPB]) ok = 1'b0;
          if (s[0] !== 1'b0 || s[9*CPB] !== 1'b1) ok = 1'b0;
          for (int b = 0; b < 8; b++) got[b] = s[(b+1)*CPB];
          check("bit_timing", ok, 1);
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_byte: got %02h, expected no byte (cycle %0d)", got, cyc);
          end else begin
            check("frame_byte", got, exp_q.pop_front());
          end
          prev = s[39];
        end
      end else begin
        prev = uart_tx;
      end
    end
  end

  initial begin : timing_mon
    int   rise_cyc;
    logic prev_busy;
    rise_cyc = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (busy === 1'b1 && prev_busy !== 1'b1) rise_cyc = cyc;
      if (done === 1'b1) begin
        done_cnt++;
        check("done_latency", cyc - rise_cyc, 1680);
        check("busy_low_at_done", busy, 0);
      end
      prev_busy = busy;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int bad;
    int dc0;
    int n;
    set_rf(32'h0);

    // Reset and quiet idle line.
    repeat (3) @(negedge clock);
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clock);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    // Single nonzero register: 12^34^56^78 = 08.
    rf_v[0] = 32'h12345678;
    push_frame(8'h08);
    pulse_start(1);
    wait_done(2000);
    repeat (20) @(negedge clock);
    check("t2_drained", exp_q.size(), 0);

    // All ones: even count of FF bytes cancels; exact start-bit width.
    set_rf(32'hFFFFFFFF);
    push_frame(8'h00);
    pulse_start(1);
    n = 0;
    while (uart_tx === 1'b0 && n < 10) begin
      n++;
      @(negedge clock);
    end
    check("start_bit_len", n, 4);
    wait_done(2000);
    repeat (20) @(negedge clock);
    check("t3_drained", exp_q.size(), 0);

    // Snapshot coherence: CA^FE^F0^0D^80 = 49; mid-frame RF change and starts are ignored.
    set_rf(32'h0);
    rf_v[0] = 32'hCAFEF00D;
    rf_v[9] = 32'h00000080;
    push_frame(8'h49);
    dc0 = done_cnt;
    pulse_start(1);
    repeat (100) @(negedge clock);
    rf_v[0] = 32'hDEADBEEF;
    pulse_start(0);
    repeat (300) @(negedge clock);
    pulse_start(0);
    wait_done(2000);
    repeat (200) @(negedge clock);
    check("t4_single_done", done_cnt - dc0, 1);
    check("t4_no_refire", busy, 0);
    check("t4_drained", exp_q.size(), 0);

    // Reset during byte 5 (bytes 0..4 complete at offset 199, byte 5 occupies 200..239).
    set_rf(32'h0);
    rf_v[0] = 32'h11223344;
    rf_v[1] = 32'h55667788;
    exp_q.push_back(8'hA5);
    for (int b = 0; b < 4; b++) exp_q.push_back(rf_v[0][31-8*b -: 8]);
    dc0 = done_cnt;
    pulse_start(1);
    repeat (212) @(negedge clock);
    mon_flush = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    check("t5_rst_tx", uart_tx, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    mon_flush = 1'b0;
    check("t5_bytes_before_rst", exp_q.size(), 0);
    repeat (50) @(negedge clock);
    check("t5_no_done", done_cnt - dc0, 0);
    // 11^22^33^44^55^66^77^88 = 88.
    push_frame(8'h88);
    pulse_start(1);
    wait_done(2000);
    repeat (20) @(negedge clock);
    check("t5_drained", exp_q.size(), 0);

    // start held high: back-to-back frames separated by DONE + IDLE cycles.
    set_rf(32'h0);
    rf_v[2] = 32'h000000AB;
    push_frame(8'hAB);
    push_frame(8'hAB);
    dc0 = done_cnt;
    @(negedge clock); start = 1'b1;
    @(negedge clock);
    check("t6_busy", busy, 1);
    wait_done(2000);
    check("t6_done_tx", uart_tx, 1);
    @(negedge clock);
    check("t6_gap_tx", uart_tx, 1);
    check("t6_gap_busy", busy, 0);
    @(negedge clock);
    check("t6_restart_tx", uart_tx, 0);
    check("t6_restart_busy", busy, 1);
    @(negedge clock);
    wait_done(2000);
    start = 1'b0;
    repeat (100) @(negedge clock);
    check("t6_idle_after", busy, 0);
    check("t6_two_done", done_cnt - dc0, 2);
    check("t6_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
